screen_seq_ctrl: RTL

- Top-level screen sequencer for the game's text overlays (title logo, "press start", "game over", "you win").
- Owns the game-phase FSM: TITLE -> PLAYING -> GAME_OVER or YOU_WIN -> TITLE.
- Counts frames from frame_clk to blink "press start" and to time out the end screens.
- Emits per-logo enables and gates the per-pixel logo hits into one text_on and a colour-select code for the colour mapper.

---
 rtl/galaga_pkg.sv | 16 +
 rtl/sync_edge_det.sv | 32 +++
 rtl/screen_seq_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/galaga_pkg.sv
// rtl/galaga_pkg.sv - shared state and text-select encodings for the screen sequencer
package galaga_pkg;

  typedef enum logic [2:0] {
    S_TITLE,
    S_PLAYING,
    S_GAME_OVER,
    S_YOU_WIN
  } screen_state_t;

  localparam logic [1:0] TXT_GALAGA   = 2'd0;
  localparam logic [1:0] TXT_PRESS    = 2'd1;
  localparam logic [1:0] TXT_GAMEOVER = 2'd2;
  localparam logic [1:0] TXT_WIN      = 2'd3;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - 2-FF synchroniser with registered rising-edge pulse
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic pulse_q;

  // Two flops to resolve metastability, a third to remember the last level,
  // and a registered pulse so the edge appears three clocks after the input edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/screen_seq_ctrl.sv
// rtl/screen_seq_ctrl.sv - game-phase FSM, frame timers and text overlay gating
module screen_seq_ctrl
  import galaga_pkg::*;
#(
  parameter int BLINK_FRAMES    = 30,
  parameter int END_HOLD_FRAMES = 300
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       player_dead,
  input  logic       all_enemies_dead,
  input  logic       is_galaga,
  input  logic       is_press_start,
  input  logic       is_gameover,
  input  logic       is_you_win,
  output logic       show_galaga,
  output logic       show_press_start,
  output logic       show_gameover,
  output logic       show_you_win,
  output logic       game_active,
  output logic       game_reset,
  output logic       text_on,
  output logic [1:0] text_sel
);

  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int HW = $clog2(END_HOLD_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(END_HOLD_FRAMES - 1);

  screen_state_t state_q, state_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  logic frame_tick;
  logic start_edge;

  logic hit_galaga;
  logic hit_press;
  logic hit_gameover;
  logic hit_win;

  sync_edge_det u_frame_sync (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .async_i (frame_clk),
    .pulse_o (frame_tick)
  );

  sync_edge_det u_start_sync (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .async_i (start_key),
    .pulse_o (start_edge)
  );

  // State and frame counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_TITLE;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  // Next-state logic; game_reset is a Mealy pulse on the start press in TITLE.
  always_comb begin
    state_d       = state_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    hold_cnt_d    = hold_cnt_q;
    game_reset    = 1'b0;
    case (state_q)
      S_TITLE: begin
        if (start_edge) begin
          game_reset    = 1'b1;
          state_d       = S_PLAYING;
          blink_cnt_d   = '0;
          blink_phase_d = 1'b1;
        end else if (frame_tick) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
        end
      end
      S_PLAYING: begin
        // A loss outranks a win when both land in the same cycle.
        if (player_dead) begin
          state_d    = S_GAME_OVER;
          hold_cnt_d = '0;
        end else if (all_enemies_dead) begin
          state_d    = S_YOU_WIN;
          hold_cnt_d = '0;
        end
      end
      S_GAME_OVER, S_YOU_WIN: begin
        // A start press only leaves the end screen; a fresh press in TITLE starts play.
        if (start_edge) begin
          state_d    = S_TITLE;
          hold_cnt_d = '0;
        end else if (frame_tick) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = S_TITLE;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
      end
      default: begin
        state_d = S_TITLE;
      end
    endcase
  end

  // Overlay enables decoded only from registered state so game inputs cannot glitch them.
  always_comb begin
    show_galaga      = 1'b0;
    show_press_start = 1'b0;
    show_gameover    = 1'b0;
    show_you_win     = 1'b0;
    game_active      = 1'b0;
    case (state_q)
      S_TITLE: begin
        show_galaga      = 1'b1;
        show_press_start = blink_phase_q;
      end
      S_PLAYING:   game_active   = 1'b1;
      S_GAME_OVER: show_gameover = 1'b1;
      S_YOU_WIN:   show_you_win  = 1'b1;
      default:     show_galaga   = 1'b0;
    endcase
  end

  assign hit_galaga   = show_galaga      & is_galaga;
  assign hit_press    = show_press_start & is_press_start;
  assign hit_gameover = show_gameover    & is_gameover;
  assign hit_win      = show_you_win     & is_you_win;

  // Merge the enabled pixel hits, highest-priority logo wins the colour select.
  always_comb begin
    text_on  = 1'b1;
    text_sel = TXT_GALAGA;
    if (hit_galaga) begin
      text_sel = TXT_GALAGA;
    end else if (hit_press) begin
      text_sel = TXT_PRESS;
    end else if (hit_gameover) begin
      text_sel = TXT_GAMEOVER;
    end else if (hit_win) begin
      text_sel = TXT_WIN;
    end else begin
      text_on  = 1'b0;
      text_sel = TXT_GALAGA;
    end
  end

endmodule
